// File: rtl/hdmi_pkg.sv
// ---------------------------------------------------------------------------
// hdmi_pkg
// Shared constants for the TMDS encoder slice:
//   TMDS_W             - width of one encoded TMDS word (10)
//   CTRL_00..CTRL_11   - control-period codes indexed by {c1,c0}
//   CH_BLUE/GREEN/RED  - channel indices (ch0 = blue, ch1 = green, ch2 = red)
//   ctrl_code()        - maps {c1,c0} to its 10-bit control code
// ---------------------------------------------------------------------------
package hdmi_pkg;

    localparam int TMDS_W = 10;

    localparam logic [TMDS_W-1:0] CTRL_00 = 10'b1101010100;
    localparam logic [TMDS_W-1:0] CTRL_01 = 10'b0010101011;
    localparam logic [TMDS_W-1:0] CTRL_10 = 10'b0101010100;
    localparam logic [TMDS_W-1:0] CTRL_11 = 10'b1010101011;

    localparam int CH_BLUE  = 0;
    localparam int CH_GREEN = 1;
    localparam int CH_RED   = 2;

    function automatic logic [TMDS_W-1:0] ctrl_code(input logic [1:0] c);
        logic [TMDS_W-1:0] code;
        case (c)
            2'b01:   code = CTRL_01;
            2'b10:   code = CTRL_10;
            2'b11:   code = CTRL_11;
            default: code = CTRL_00;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// ---------------------------------------------------------------------------
// tmds_channel_enc
// Two-stage TMDS 8b/10b encoder for one channel.
//   Stage 1: transition-minimising q_m[8:0], plus de and control bits.
//   Stage 2: DC-balancing with a running 5-bit signed disparity counter,
//            or a control code during blanking.
// Ports:
//   vga_clk   in   pixel clock (rising edge)
//   sys_rst_n in   asynchronous active-low reset, clears every register
//   d         in   8-bit pixel component
//   c         in   control bits {c1,c0} used while de = 0
//   de        in   data enable
//   tmds      out  registered 10-bit TMDS word, two cycles after input
// ---------------------------------------------------------------------------
module tmds_channel_enc
    import hdmi_pkg::*;
(
    input  logic              vga_clk,
    input  logic              sys_rst_n,
    input  logic [7:0]        d,
    input  logic [1:0]        c,
    input  logic              de,
    output logic [TMDS_W-1:0] tmds
);

    logic [3:0]              n1;
    logic                    use_xnor;
    logic [8:0]              q_m_d, q_m_q;
    logic                    de_q;
    logic [1:0]              c_q;

    logic [3:0]              n1q, n0q;
    logic signed [4:0]       diff;
    logic signed [4:0]       cnt_d, cnt_q;
    logic [TMDS_W-1:0]       tmds_d, tmds_q;

    // Stage 1: choose XOR/XNOR chaining to minimise transitions
    always_comb begin
        n1 = 4'd0;
        for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, d[i]};
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);

        q_m_d    = 9'd0;
        q_m_d[0] = d[0];
        for (int i = 1; i < 8; i++)
            q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ d[i]) : (q_m_d[i-1] ^ d[i]);
        q_m_d[8] = ~use_xnor;
    end

    // Stage 2: DC balance against the running disparity
    always_comb begin
        n1q = 4'd0;
        for (int i = 0; i < 8; i++) n1q = n1q + {3'b000, q_m_q[i]};
        n0q  = 4'd8 - n1q;
        diff = $signed({1'b0, n1q}) - $signed({1'b0, n0q});

        tmds_d = tmds_q;
        cnt_d  = cnt_q;
        if (!de_q) begin
            tmds_d = ctrl_code(c_q);
            cnt_d  = 5'sd0;
        end else if ((cnt_q == 5'sd0) || (diff == 5'sd0)) begin
            tmds_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
            cnt_d  = cnt_q + (q_m_q[8] ? diff : -diff);
        end else if (((cnt_q > 5'sd0) && (diff > 5'sd0)) ||
                     ((cnt_q < 5'sd0) && (diff < 5'sd0))) begin
            // Inverting pulls disparity back toward zero
            tmds_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
            cnt_d  = cnt_q + (q_m_q[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
            tmds_d = {1'b0, q_m_q[8], q_m_q[7:0]};
            cnt_d  = cnt_q + diff - (q_m_q[8] ? 5'sd0 : 5'sd2);
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            q_m_q  <= 9'd0;
            de_q   <= 1'b0;
            c_q    <= 2'b00;
            cnt_q  <= 5'sd0;
            tmds_q <= '0;
        end else begin
            q_m_q  <= q_m_d;
            de_q   <= de;
            c_q    <= c;
            cnt_q  <= cnt_d;
            tmds_q <= tmds_d;
        end
    end

    assign tmds = tmds_q;

endmodule

// File: rtl/rgb_to_tmds.sv
// ---------------------------------------------------------------------------
// rgb_to_tmds
// RGB565 pixel + syncs to three TMDS channel words, 2-cycle latency.
// Ports:
//   vga_clk    in   pixel clock
//   sys_rst_n  in   asynchronous active-low reset
//   rgb[15:0]  in   RGB565 pixel ([15:11] R, [10:5] G, [4:0] B)
//   hsync      in   horizontal sync, polarity set by SYNC_POL
//   vsync      in   vertical sync, polarity set by SYNC_POL
//   de         in   data enable (1 = active pixel)
//   tmds_ch0   out  blue channel, carries {vs,hs} in blanking
//   tmds_ch1   out  green channel
//   tmds_ch2   out  red channel
// Parameter SYNC_POL: 1 = syncs active-high, 0 = active-low.
// Macro RGB_EXPAND_REPLICATE_EN: defined -> MSB replication into the low
// bits when widening to 8 bits; undefined -> zero fill.
// ---------------------------------------------------------------------------
module rgb_to_tmds
    import hdmi_pkg::*;
#(
    parameter bit SYNC_POL = 1'b1
) (
    input  logic              vga_clk,
    input  logic              sys_rst_n,
    input  logic [15:0]       rgb,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              de,
    output logic [TMDS_W-1:0] tmds_ch0,
    output logic [TMDS_W-1:0] tmds_ch1,
    output logic [TMDS_W-1:0] tmds_ch2
);

    logic [7:0] chan_d [3];
    logic       hs, vs;

`ifdef RGB_EXPAND_REPLICATE_EN
    assign chan_d[CH_RED]   = {rgb[15:11], rgb[15:13]};
    assign chan_d[CH_GREEN] = {rgb[10:5],  rgb[10:9]};
    assign chan_d[CH_BLUE]  = {rgb[4:0],   rgb[4:2]};
`else
    assign chan_d[CH_RED]   = {rgb[15:11], 3'b000};
    assign chan_d[CH_GREEN] = {rgb[10:5],  2'b00};
    assign chan_d[CH_BLUE]  = {rgb[4:0],   3'b000};
`endif

    // Normalise to active-high regardless of the timing generator's polarity
    assign hs = hsync ^ ~SYNC_POL;
    assign vs = vsync ^ ~SYNC_POL;

    tmds_channel_enc u_enc_blue (
        .vga_clk  (vga_clk),
        .sys_rst_n(sys_rst_n),
        .d        (chan_d[CH_BLUE]),
        .c        ({vs, hs}),
        .de       (de),
        .tmds     (tmds_ch0)
    );

    tmds_channel_enc u_enc_green (
        .vga_clk  (vga_clk),
        .sys_rst_n(sys_rst_n),
        .d        (chan_d[CH_GREEN]),
        .c        (2'b00),
        .de       (de),
        .tmds     (tmds_ch1)
    );

    tmds_channel_enc u_enc_red (
        .vga_clk  (vga_clk),
        .sys_rst_n(sys_rst_n),
        .d        (chan_d[CH_RED]),
        .c        (2'b00),
        .de       (de),
        .tmds     (tmds_ch2)
    );

endmodule

// File: tb/tb_rgb_to_tmds.sv
// ---------------------------------------------------------------------------
// tb_rgb_to_tmds
// Directed and random checks of rgb_to_tmds. Two instances share the
// stimulus: dut_a with SYNC_POL=1, dut_b with SYNC_POL=0.
// Honours RGB_EXPAND_REPLICATE_EN for the expected expansion.
// ---------------------------------------------------------------------------
module tb_rgb_to_tmds;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n;
    logic [15:0] rgb;
    logic        hsync, vsync, de;
    logic [9:0]  a_ch0, a_ch1, a_ch2;
    logic [9:0]  b_ch0, b_ch1, b_ch2;

    int total = 0;
    int bad   = 0;

    rgb_to_tmds #(.SYNC_POL(1'b1)) dut_a (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .rgb(rgb),
        .hsync(hsync), .vsync(vsync), .de(de),
        .tmds_ch0(a_ch0), .tmds_ch1(a_ch1), .tmds_ch2(a_ch2)
    );

    rgb_to_tmds #(.SYNC_POL(1'b0)) dut_b (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .rgb(rgb),
        .hsync(hsync), .vsync(vsync), .de(de),
        .tmds_ch0(b_ch0), .tmds_ch1(b_ch1), .tmds_ch2(b_ch2)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one input sample, clock it in, then settle past the edge
    task automatic step(input logic [15:0] p, input logic h, input logic v, input logic e);
        rgb = p; hsync = h; vsync = v; de = e;
        @(posedge vga_clk);
        #1;
    endtask

    // Reference TMDS encoder, written from the algorithm description
    function automatic logic [9:0] model_enc(input logic [7:0] d, input logic [1:0] c,
                                             input logic e, inout int disp);
        int         ones, qo, qz;
        logic [8:0] q;
        logic [9:0] r;
        if (!e) begin
            disp = 0;
            case (c)
                2'b00: r = 10'b1101010100;
                2'b01: r = 10'b0010101011;
                2'b10: r = 10'b0101010100;
                default: r = 10'b1010101011;
            endcase
            return r;
        end
        ones = $countones(d);
        q[0] = d[0];
        if (ones > 4 || (ones == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) q[i] = q[i-1] ~^ d[i];
            q[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
            q[8] = 1'b1;
        end
        qo = $countones(q[7:0]);
        qz = 8 - qo;
        if (disp == 0 || qo == qz) begin
            if (q[8]) begin r = {2'b01, q[7:0]};  disp = disp + qo - qz; end
            else      begin r = {2'b10, ~q[7:0]}; disp = disp + qz - qo; end
        end else if ((disp > 0 && qo > qz) || (disp < 0 && qz > qo)) begin
            r = {1'b1, q[8], ~q[7:0]};
            disp = disp + (q[8] ? 2 : 0) + qz - qo;
        end else begin
            r = {1'b0, q[8], q[7:0]};
            disp = disp + qo - qz - (q[8] ? 0 : 2);
        end
        return r;
    endfunction

    function automatic logic [23:0] expand(input logic [15:0] p);
`ifdef RGB_EXPAND_REPLICATE_EN
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
`else
        return {p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 3'b000};
`endif
    endfunction

    initial begin
        logic [9:0]  exp_ffff_rb, exp_ffff_g;
        logic [23:0] x;
        logic [9:0]  e0, e1, e2, p0, p1, p2;
        logic        have_prev;
        int          d0, d1, d2;
        logic [15:0] rp;
        logic        rh, rv, re;

`ifdef RGB_EXPAND_REPLICATE_EN
        exp_ffff_rb = 10'h200;
        exp_ffff_g  = 10'h200;
`else
        exp_ffff_rb = 10'h2FD;
        exp_ffff_g  = 10'h201;
`endif

        // Reset state
        sys_rst_n = 1'b0;
        rgb = 16'h1234; hsync = 1'b1; vsync = 1'b1; de = 1'b1;
        repeat (3) @(posedge vga_clk);
        #1;
        chk("rst_ch0", a_ch0, 10'h000);
        chk("rst_ch1", a_ch1, 10'h000);
        chk("rst_ch2", a_ch2, 10'h000);
        chk_int("rst_cnt0", int'(dut_a.u_enc_blue.cnt_q), 0);
        sys_rst_n = 1'b1;

        // Blanking with hsync active, SYNC_POL=1 and SYNC_POL=0
        step(16'h0000, 1'b1, 1'b0, 1'b0);
        step(16'h0000, 1'b1, 1'b0, 1'b0);
        chk("hs_ch0",   a_ch0, 10'b0010101011);
        chk("hs_ch1",   a_ch1, 10'b1101010100);
        chk("hs_ch2",   a_ch2, 10'b1101010100);
        chk("hs_b_ch0", b_ch0, 10'b0101010100);

        step(16'h0000, 1'b0, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b1, 1'b0);
        chk("pol0_ch0", b_ch0, 10'b0010101011);
        chk("pol1_ch0", a_ch0, 10'b0101010100);
        chk("pol0_ch1", b_ch1, 10'b1101010100);

        // Black run after blanking: disparity -8, +2, -6
        step(16'h0000, 1'b0, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b0, 1'b1);
        chk("blk1_ch0", a_ch0, 10'h100);
        chk_int("blk1_cnt", int'(dut_a.u_enc_blue.cnt_q), -8);
        step(16'h0000, 1'b0, 1'b0, 1'b1);
        chk("blk2_ch0", a_ch0, 10'h3FF);
        chk_int("blk2_cnt", int'(dut_a.u_enc_blue.cnt_q), 2);
        step(16'h0000, 1'b0, 1'b0, 1'b0);
        chk("blk3_ch0", a_ch0, 10'h100);
        chk_int("blk3_cnt", int'(dut_a.u_enc_blue.cnt_q), -6);
        step(16'h0000, 1'b0, 1'b0, 1'b0);
        chk("blank_ch0", a_ch0, 10'b1101010100);
        chk_int("blank_cnt", int'(dut_a.u_enc_blue.cnt_q), 0);

        // White pixel after blanking
        step(16'hFFFF, 1'b0, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b0, 1'b0);
        chk("white_ch2", a_ch2, exp_ffff_rb);
        chk("white_ch1", a_ch1, exp_ffff_g);
        chk("white_ch0", a_ch0, exp_ffff_rb);

        // Asynchronous reset mid-line, no clock edge needed
        step(16'h0000, 1'b0, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b0, 1'b1);
        chk("pre_rst_ch0", a_ch0, 10'h3FF);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_ch0", a_ch0, 10'h000);
        chk("arst_ch1", a_ch1, 10'h000);
        chk("arst_ch2", a_ch2, 10'h000);
        chk("arst_b_ch0", b_ch0, 10'h000);
        @(posedge vga_clk);
        #2;
        sys_rst_n = 1'b1;
        step(16'h0000, 1'b0, 1'b0, 1'b1);
        chk("rel_ctrl_ch0", a_ch0, 10'b1101010100);
        step(16'h0000, 1'b0, 1'b0, 1'b1);
        chk("rel_blk_ch0", a_ch0, 10'h100);

        // Random stream vs reference model; blank first so disparity starts at 0
        step(16'h0000, 1'b0, 1'b0, 1'b0);
        d0 = 0; d1 = 0; d2 = 0;
        have_prev = 1'b0;
        p0 = '0; p1 = '0; p2 = '0;
        for (int n = 0; n < 300; n++) begin
            rp = 16'($urandom);
            rh = 1'($urandom);
            rv = 1'($urandom);
            re = ($urandom_range(0, 3) != 0);
            x  = expand(rp);
            e0 = model_enc(x[7:0],   {rv, rh}, re, d0);
            e1 = model_enc(x[15:8],  2'b00,    re, d1);
            e2 = model_enc(x[23:16], 2'b00,    re, d2);
            step(rp, rh, rv, re);
            if (have_prev) begin
                chk("rnd_ch0", a_ch0, p0);
                chk("rnd_ch1", a_ch1, p1);
                chk("rnd_ch2", a_ch2, p2);
            end
            chk_int("rnd_bound0", int'(($signed(dut_a.u_enc_blue.cnt_q)  >= -10) && ($signed(dut_a.u_enc_blue.cnt_q)  <= 10)), 1);
            chk_int("rnd_bound1", int'(($signed(dut_a.u_enc_green.cnt_q) >= -10) && ($signed(dut_a.u_enc_green.cnt_q) <= 10)), 1);
            chk_int("rnd_bound2", int'(($signed(dut_a.u_enc_red.cnt_q)   >= -10) && ($signed(dut_a.u_enc_red.cnt_q)   <= 10)), 1);
            p0 = e0; p1 = e1; p2 = e2;
            have_prev = 1'b1;
        end
        step(16'h0000, 1'b0, 1'b0, 1'b0);
        chk("rnd_last_ch0", a_ch0, p0);
        chk("rnd_last_ch1", a_ch1, p1);
        chk("rnd_last_ch2", a_ch2, p2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
